acc_cpu_core: RTL and testbench

//  Parametrised accumulator CPU core; next generation of the 8-bit RISC datapath.

---
 rtl/acc_cpu_pkg.sv | 29 ++
 rtl/acc_cpu_if.sv | 22 ++
 rtl/acc_cpu_alu.sv | 32 +++
 rtl/acc_cpu_core.sv | 150 +++++++++++++++
 tb/tb_acc_cpu_core.sv | 343 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/acc_cpu_pkg.sv
// Shared definitions for the accumulator CPU: opcodes, controller states and
// the parameter sanity check on instruction word width.
package acc_cpu_pkg;

  typedef enum logic [2:0] {
    OpHlt = 3'd0,
    OpSkz = 3'd1,
    OpAdd = 3'd2,
    OpAnd = 3'd3,
    OpXor = 3'd4,
    OpLda = 3'd5,
    OpSto = 3'd6,
    OpJmp = 3'd7
  } opcode_e;

  typedef enum logic [2:0] {
    StFetch,
    StDecode,
    StRead,
    StWrite,
    StHalt
  } state_e;

  // The word must hold a 3-bit opcode above the address field.
  function automatic bit widths_ok(input int unsigned data_w, input int unsigned addr_w);
    return data_w >= addr_w + 3;
  endfunction

endpackage

// File: rtl/acc_cpu_if.sv
// Single memory port of the accumulator CPU: req/ack handshake, any latency.
interface acc_cpu_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 5
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/acc_cpu_alu.sv
// Combinational ALU for the accumulator CPU: ADD/AND/XOR, otherwise passes the
// memory operand through (LDA). Carry-out is only meaningful for ADD.
module acc_cpu_alu
  import acc_cpu_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  opcode_e           op_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] res_o,
  output logic              carry_o
);

  logic [DATA_W:0] sum;

  always_comb begin
    sum     = {1'b0, a_i} + {1'b0, b_i};
    res_o   = b_i;
    carry_o = 1'b0;
    unique case (op_i)
      OpAdd: begin
        res_o   = sum[DATA_W-1:0];
        carry_o = sum[DATA_W];
      end
      OpAnd:   res_o = a_i & b_i;
      OpXor:   res_o = a_i ^ b_i;
      default: ;
    endcase
  end

endmodule

// File: rtl/acc_cpu_core.sv
// Multi-cycle accumulator CPU core: PC, IR, ACC and controller on one req/ack memory port.
// Optional ADD carry flag (also tested by SKZ) enabled by defining ACC_CPU_CARRY_EN.
module acc_cpu_core
  import acc_cpu_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned RST_PC = 0
) (
  input  logic              clk,
  input  logic              rst,
  acc_cpu_if.master         mem,
  output logic              halted,
  output logic [ADDR_W-1:0] pc_dbg,
  output logic [DATA_W-1:0] acc_dbg,
  output logic              carry
);

  if (!widths_ok(DATA_W, ADDR_W)) begin : g_width_check
    $error("acc_cpu_core: DATA_W must be at least ADDR_W+3");
  end

  state_e            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [DATA_W-1:0] ir_q;
  logic [DATA_W-1:0] acc_q;
  logic              carry_q;
  logic              halted_q;
  logic              req_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  opcode_e           opcode;
  logic [ADDR_W-1:0] op_addr;
  logic [DATA_W-1:0] alu_res;
  logic              alu_carry;
  logic              carry_upd;
  logic              skip;

  assign opcode  = opcode_e'(ir_q[DATA_W-1 -: 3]);
  assign op_addr = ir_q[ADDR_W-1:0];

  acc_cpu_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .op_i    (opcode),
    .a_i     (acc_q),
    .b_i     (mem.mem_rdata),
    .res_o   (alu_res),
    .carry_o (alu_carry)
  );

`ifdef ACC_CPU_CARRY_EN
  // ALU reports 0 for AND/XOR/LDA, so those clear the flag.
  assign carry_upd = alu_carry;
  assign skip      = (acc_q == '0) || carry_q;
`else
  logic unused_alu_carry;
  assign unused_alu_carry = alu_carry;
  assign carry_upd        = 1'b0;
  assign skip             = (acc_q == '0);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StFetch;
      pc_q     <= ADDR_W'(RST_PC);
      ir_q     <= '0;
      acc_q    <= '0;
      carry_q  <= 1'b0;
      halted_q <= 1'b0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      case (state_q)
        // Each access state spends one idle cycle issuing the request, which
        // also guarantees the mandatory gap between consecutive requests.
        StFetch: begin
          if (!req_q) begin
            req_q  <= 1'b1;
            we_q   <= 1'b0;
            addr_q <= pc_q;
          end else if (mem.mem_ack) begin
            req_q   <= 1'b0;
            ir_q    <= mem.mem_rdata;
            pc_q    <= pc_q + 1'b1;
            state_q <= StDecode;
          end
        end
        StDecode: begin
          unique case (opcode)
            OpHlt: begin
              halted_q <= 1'b1;
              state_q  <= StHalt;
            end
            OpSkz: begin
              if (skip) pc_q <= pc_q + 1'b1;
              state_q <= StFetch;
            end
            OpJmp: begin
              pc_q    <= op_addr;
              state_q <= StFetch;
            end
            OpSto:   state_q <= StWrite;
            default: state_q <= StRead;
          endcase
        end
        StRead: begin
          if (!req_q) begin
            req_q  <= 1'b1;
            we_q   <= 1'b0;
            addr_q <= op_addr;
          end else if (mem.mem_ack) begin
            req_q   <= 1'b0;
            acc_q   <= alu_res;
            carry_q <= carry_upd;
            state_q <= StFetch;
          end
        end
        StWrite: begin
          if (!req_q) begin
            req_q   <= 1'b1;
            we_q    <= 1'b1;
            addr_q  <= op_addr;
            wdata_q <= acc_q;
          end else if (mem.mem_ack) begin
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            state_q <= StFetch;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem.mem_req   = req_q;
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;

  assign halted  = halted_q;
  assign pc_dbg  = pc_q;
  assign acc_dbg = acc_q;
  assign carry   = carry_q;

endmodule

// File: tb/tb_acc_cpu_core.sv
// Scoreboard bench for acc_cpu_core: directed programs push the expected memory
// access trace and halt state; a monitor compares them as the DUT presents them.
module tb_acc_cpu_core;

  localparam logic [2:0] HLT = 3'd0;
  localparam logic [2:0] SKZ = 3'd1;
  localparam logic [2:0] ADD = 3'd2;
  localparam logic [2:0] AND = 3'd3;
  localparam logic [2:0] XOR = 3'd4;
  localparam logic [2:0] LDA = 3'd5;
  localparam logic [2:0] STO = 3'd6;
  localparam logic [2:0] JMP = 3'd7;

  typedef struct {
    bit         we;
    logic [4:0] addr;
    logic [7:0] wdata;
  } acc_t;

  typedef struct {
    logic [4:0] pc;
    logic [7:0] acc;
    logic       carry;
  } halt_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       halted;
  logic [4:0] pc_dbg;
  logic [7:0] acc_dbg;
  logic       carry;

  logic [7:0] mem [32];
  acc_t       exp_q [$];
  halt_t      halt_q [$];

  int  n_cmp = 0;
  int  n_err = 0;
  bit  sb_on = 0;
  bit  rand_dly = 0;
  bit  spur = 0;
  bit  block_en = 0;
  logic [4:0] block_addr = '0;
  bit  halt_seen = 0;
  int  cyc_cnt = 0;
  int  halt_cyc = 0;

  acc_cpu_if #(.DATA_W(8), .ADDR_W(5)) mif ();

  acc_cpu_core #(
    .DATA_W (8),
    .ADDR_W (5),
    .RST_PC (0)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .mem     (mif),
    .halted  (halted),
    .pc_dbg  (pc_dbg),
    .acc_dbg (acc_dbg),
    .carry   (carry)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] ins(input logic [2:0] op, input logic [4:0] a);
    return {op, a};
  endfunction

  task automatic exp_rd(input logic [4:0] a);
    acc_t t;
    t.we = 1'b0; t.addr = a; t.wdata = '0;
    exp_q.push_back(t);
  endtask

  task automatic exp_wr(input logic [4:0] a, input logic [7:0] d);
    acc_t t;
    t.we = 1'b1; t.addr = a; t.wdata = d;
    exp_q.push_back(t);
  endtask

  task automatic exp_halt(input logic [4:0] pc, input logic [7:0] acc, input logic c);
    halt_t h;
    h.pc = pc; h.acc = acc; h.carry = c;
    halt_q.push_back(h);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 32; i++) mem[i] = 8'h00;
  endtask

  task automatic wait_drain(input string name, input bit halts);
    int cyc;
    cyc = 0;
    while ((exp_q.size() != 0 || (halts && halt_q.size() != 0)) && cyc < 600) begin
      @(posedge clk);
      cyc++;
    end
    if (exp_q.size() != 0 || (halts && halt_q.size() != 0)) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s timeout: %0d accesses, %0d halts outstanding", name, exp_q.size(),
               halt_q.size());
      exp_q.delete();
      halt_q.delete();
    end
  endtask

  // Releases reset, runs to the end of the expected trace, then resets again.
  task automatic run_prog(input string name, input bit halts);
    sb_on = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    wait_drain(name, halts);
    if (halts) repeat (4) @(posedge clk);
    sb_on = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial forever begin
    @(posedge clk);
    if (!rst) cyc_cnt = 0;
    else cyc_cnt++;
  end

  // Memory model: random or zero ack latency, optional spurious ack while idle.
  initial begin : mem_model
    bit         pend;
    int         cnt;
    bit         c_we;
    logic [4:0] c_addr;
    logic [7:0] c_wdata;
    pend = 0;
    cnt = 0;
    mif.mem_ack = 1'b0;
    mif.mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      mif.mem_ack = 1'b0;
      if (!rst || !mif.mem_req) begin
        pend = 0;
        if (spur && rst) begin
          mif.mem_ack = 1'b1;
          mif.mem_rdata = 8'hFF;
        end
      end else begin
        if (!pend) begin
          pend = 1;
          c_we = mif.mem_we;
          c_addr = mif.mem_addr;
          c_wdata = mif.mem_wdata;
          cnt = rand_dly ? int'($urandom_range(0, 7)) : 0;
        end else begin
          chk("stable_we", 32'(mif.mem_we), 32'(c_we));
          chk("stable_addr", 32'(mif.mem_addr), 32'(c_addr));
          if (c_we) chk("stable_wdata", 32'(mif.mem_wdata), 32'(c_wdata));
        end
        if (block_en && mif.mem_addr == block_addr) begin
          cnt = cnt;
        end else if (cnt == 0) begin
          mif.mem_ack = 1'b1;
          if (mif.mem_we) mem[mif.mem_addr] = mif.mem_wdata;
          else mif.mem_rdata = mem[mif.mem_addr];
          pend = 0;
        end else begin
          cnt--;
        end
      end
    end
  end

  initial begin : monitor
    acc_t  t;
    halt_t h;
    forever begin
      @(negedge clk);
      if (rst && sb_on && mif.mem_req && mif.mem_ack) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_access: we=%0d addr=%0d, expected none", mif.mem_we,
                   mif.mem_addr);
        end else begin
          t = exp_q.pop_front();
          chk("acc_we", 32'(mif.mem_we), 32'(t.we));
          chk("acc_addr", 32'(mif.mem_addr), 32'(t.addr));
          if (t.we) chk("acc_wdata", 32'(mif.mem_wdata), 32'(t.wdata));
        end
      end
      if (!rst) begin
        halt_seen = 0;
      end else if (sb_on && halted && !halt_seen) begin
        halt_seen = 1;
        halt_cyc = cyc_cnt;
        if (halt_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_halt: pc=%0d, expected no halt", pc_dbg);
        end else begin
          h = halt_q.pop_front();
          chk("halt_pc", 32'(pc_dbg), 32'(h.pc));
          chk("halt_acc", 32'(acc_dbg), 32'(h.acc));
          chk("halt_carry", 32'(carry), 32'(h.carry));
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    rst = 1'b0;
    clear_mem();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req", 32'(mif.mem_req), 0);
    chk("rst_we", 32'(mif.mem_we), 0);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_pc", 32'(pc_dbg), 0);
    chk("rst_acc", 32'(acc_dbg), 0);
    chk("rst_carry", 32'(carry), 0);

    // LDA 10; ADD 11; STO 12; HLT -- zero latency, then random latency + spurious acks.
    for (int pass = 0; pass < 2; pass++) begin
      clear_mem();
      mem[0] = ins(LDA, 10); mem[1] = ins(ADD, 11); mem[2] = ins(STO, 12); mem[3] = ins(HLT, 0);
      mem[10] = 8'h05; mem[11] = 8'h03;
      rand_dly = (pass == 1);
      spur = (pass == 1);
      exp_rd(0); exp_rd(10); exp_rd(1); exp_rd(11); exp_rd(2); exp_wr(12, 8'h08); exp_rd(3);
      exp_halt(4, 8'h08, 1'b0);
      run_prog("lda_add_sto", 1'b1);
      chk("mem12", 32'(mem[12]), 32'h08);
      if (pass == 0) chk("hlt_cycles", 32'(halt_cyc), 18);
    end
    rand_dly = 0;
    spur = 0;

    // SKZ at 31 with ACC=0: PC wraps past 0 to 1.
    clear_mem();
    mem[0] = ins(JMP, 31); mem[31] = ins(SKZ, 0); mem[1] = ins(HLT, 0);
    exp_rd(0); exp_rd(31); exp_rd(1);
    exp_halt(2, 8'h00, 1'b0);
    run_prog("skz_wrap_zero", 1'b1);

    // SKZ at 31 with ACC=1: no skip, next fetch at 0.
    clear_mem();
    mem[0] = ins(LDA, 20); mem[1] = ins(JMP, 31); mem[31] = ins(SKZ, 0); mem[20] = 8'h01;
    exp_rd(0); exp_rd(20); exp_rd(1); exp_rd(31); exp_rd(0);
    run_prog("skz_wrap_one", 1'b0);

    // JMP 20; XOR with equal value -> 0; SKZ skips the HLT at 22.
    clear_mem();
    mem[0] = ins(LDA, 25); mem[1] = ins(JMP, 20); mem[20] = ins(XOR, 25);
    mem[21] = ins(SKZ, 0); mem[22] = ins(HLT, 0); mem[23] = ins(STO, 26);
    mem[24] = ins(HLT, 0); mem[25] = 8'h5A; mem[26] = 8'hEE;
    exp_rd(0); exp_rd(25); exp_rd(1); exp_rd(20); exp_rd(25); exp_rd(21); exp_rd(23);
    exp_wr(26, 8'h00); exp_rd(24);
    exp_halt(25, 8'h00, 1'b0);
    run_prog("jmp_xor_skz", 1'b1);

    // ADD overflow to 0, SKZ skips, then AND and STO.
    clear_mem();
    mem[0] = ins(LDA, 10); mem[1] = ins(ADD, 11); mem[2] = ins(SKZ, 0); mem[3] = ins(HLT, 0);
    mem[4] = ins(LDA, 12); mem[5] = ins(AND, 13); mem[6] = ins(STO, 14); mem[7] = ins(HLT, 0);
    mem[10] = 8'hFF; mem[11] = 8'h01; mem[12] = 8'hF0; mem[13] = 8'h3C;
    exp_rd(0); exp_rd(10); exp_rd(1); exp_rd(11); exp_rd(2); exp_rd(4); exp_rd(12);
    exp_rd(5); exp_rd(13); exp_rd(6); exp_wr(14, 8'h30); exp_rd(7);
    exp_halt(8, 8'h30, 1'b0);
    run_prog("add_wrap_and", 1'b1);

    // 8'hFF + 8'h01 halting right after: carry visible only with the flag built in.
    clear_mem();
    mem[0] = ins(LDA, 10); mem[1] = ins(ADD, 11); mem[2] = ins(HLT, 0);
    mem[10] = 8'hFF; mem[11] = 8'h01;
    exp_rd(0); exp_rd(10); exp_rd(1); exp_rd(11); exp_rd(2);
`ifdef ACC_CPU_CARRY_EN
    exp_halt(3, 8'h00, 1'b1);
`else
    exp_halt(3, 8'h00, 1'b0);
`endif
    run_prog("add_carry", 1'b1);

    // Reset while a READ request is outstanding.
    clear_mem();
    mem[0] = ins(LDA, 10); mem[10] = 8'h77;
    block_en = 1;
    block_addr = 5'd10;
    exp_rd(0);
    sb_on = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    begin
      int cyc;
      cyc = 0;
      while (!(mif.mem_req && mif.mem_addr == 5'd10) && cyc < 100) begin
        @(negedge clk);
        cyc++;
      end
      chk("read_req_seen", 32'(mif.mem_req && mif.mem_addr == 5'd10), 1);
    end
    repeat (2) @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("async_req_drop", 32'(mif.mem_req), 0);
    chk("async_pc", 32'(pc_dbg), 0);
    block_en = 0;
    exp_q.delete();
    exp_rd(0); exp_rd(10);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("first_req", 32'(mif.mem_req), 1);
    chk("first_addr", 32'(mif.mem_addr), 0);
    wait_drain("reset_mid_read", 1'b0);
    #1;
    chk("lda_after_reset", 32'(acc_dbg), 32'h77);
    sb_on = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
